// File: rtl/garuda_buf_pkg.sv
// Shared types and default geometry for the Garuda N-bank ping-pong buffer.
// Width helpers keep the top and the bank macro in agreement on derived widths.
package garuda_buf_pkg;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    localparam int unsigned DEF_DEPTH      = 4096;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_NUM_BANKS  = 2;
    localparam int unsigned DEF_RD_LATENCY = 1;

    function automatic int addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int bank_w(input int unsigned num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int be_w(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/garuda_sram_bank.sv
// Single buffer bank: byte-enable write port and a registered read port.
// The array is deliberately left without reset so it maps onto a plain SRAM macro.
module garuda_sram_bank
    import garuda_buf_pkg::*;
#(
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]  wr_addr_i,
    input  logic [DATA_WIDTH-1:0]     wr_data_i,
    input  logic [DATA_WIDTH/8-1:0]   wr_be_i,
    input  logic                      rd_en_i,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr_i,
    output logic [DATA_WIDTH-1:0]     rd_data_o
);

    localparam int BE_W = be_w(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be_i[b]) begin
                    mem_q[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/garuda_pingpong_buffer.sv
// N-bank ownership-tracked buffer between the DMA/load unit and the lane array.
// Producer fills and commits banks in round-robin order; consumer reads and releases them.
//
// bank state | meaning
// BANK_EMPTY | owned by the producer; writes and commit accepted when pointed at
// BANK_FULL  | owned by the consumer; reads and release accepted when pointed at
module garuda_pingpong_buffer
    import garuda_buf_pkg::*;
#(
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_BANKS  = DEF_NUM_BANKS,
    parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]       wr_addr_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    input  logic [DATA_WIDTH/8-1:0]        wr_be_i,
    input  logic                           wr_commit_i,
    output logic                           wr_bank_ready_o,
    output logic [$clog2(NUM_BANKS)-1:0]   wr_bank_o,
    input  logic                           rd_en_i,
    input  logic [$clog2(DEPTH)-1:0]       rd_addr_i,
    input  logic                           rd_release_i,
    output logic                           rd_bank_valid_o,
    output logic [$clog2(NUM_BANKS)-1:0]   rd_bank_o,
    output logic                           rd_valid_o,
    output logic [DATA_WIDTH-1:0]          rd_data_o,
    output logic [$clog2(NUM_BANKS):0]     full_count_o,
    output logic                           err_o
);

    localparam int BANK_W = bank_w(NUM_BANKS);
    localparam int CNT_W  = BANK_W + 1;

    bank_state_e           bank_state_q [NUM_BANKS];
    bank_state_e           bank_state_d [NUM_BANKS];
    logic [BANK_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [BANK_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      full_cnt_q, full_cnt_d;
    logic                  err_q, err_d;

    logic                  wr_ok, commit_ok, rd_ok, release_ok;

    assign wr_bank_ready_o = (bank_state_q[wr_ptr_q] == BANK_EMPTY);
    assign rd_bank_valid_o = (bank_state_q[rd_ptr_q] == BANK_FULL);

    assign wr_ok      = wr_en_i      && wr_bank_ready_o;
    assign commit_ok  = wr_commit_i  && wr_bank_ready_o;
    assign rd_ok      = rd_en_i      && rd_bank_valid_o;
    assign release_ok = rd_release_i && rd_bank_valid_o;

    assign wr_bank_o    = wr_ptr_q;
    assign rd_bank_o    = rd_ptr_q;
    assign full_count_o = full_cnt_q;
    assign err_o        = err_q;

    // Commit and release never hit the same bank: one needs EMPTY, the other FULL.
    always_comb begin
        bank_state_d = bank_state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        full_cnt_d   = full_cnt_q;
        err_d        = 1'b0;

        if (commit_ok) begin
            bank_state_d[wr_ptr_q] = BANK_FULL;
            wr_ptr_d               = wr_ptr_q + BANK_W'(1);
        end
        if (release_ok) begin
            bank_state_d[rd_ptr_q] = BANK_EMPTY;
            rd_ptr_d               = rd_ptr_q + BANK_W'(1);
        end

        case ({commit_ok, release_ok})
            2'b10:   full_cnt_d = full_cnt_q + CNT_W'(1);
            2'b01:   full_cnt_d = full_cnt_q - CNT_W'(1);
            default: full_cnt_d = full_cnt_q;
        endcase

        err_d = (wr_en_i      && !wr_bank_ready_o) ||
                (wr_commit_i  && !wr_bank_ready_o) ||
                (rd_en_i      && !rd_bank_valid_o) ||
                (rd_release_i && !rd_bank_valid_o);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_state_q[i] <= BANK_EMPTY;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            bank_state_q <= bank_state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            full_cnt_q   <= full_cnt_d;
            err_q        <= err_d;
        end
    end

    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        garuda_sram_bank #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk_i     (clk_i),
            .wr_en_i   (wr_ok && (wr_ptr_q == BANK_W'(b))),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .wr_be_i   (wr_be_i),
            .rd_en_i   (rd_ok && (rd_ptr_q == BANK_W'(b))),
            .rd_addr_i (rd_addr_i),
            .rd_data_o (bank_rdata[b])
        );
    end

    // Stage 1 is the bank's own read register; remember which bank it came from.
    logic                  rd_v1_q;
    logic [BANK_W-1:0]     rd_sel_q;
    logic [DATA_WIDTH-1:0] stage1_data;
    logic [DATA_WIDTH-1:0] pipe_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_v1_q  <= 1'b0;
            rd_sel_q <= '0;
        end else begin
            rd_v1_q <= rd_ok;
            if (rd_ok) begin
                rd_sel_q <= rd_ptr_q;
            end
        end
    end

    assign stage1_data = bank_rdata[rd_sel_q];

    if (RD_LATENCY == 1) begin : g_lat1
        assign rd_valid_o = rd_v1_q;
        assign pipe_data  = stage1_data;
    end else begin : g_lat2
        logic                  rd_v2_q;
        logic [DATA_WIDTH-1:0] rd_d2_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_v2_q <= 1'b0;
                rd_d2_q <= '0;
            end else begin
                rd_v2_q <= rd_v1_q;
                if (rd_v1_q) begin
                    rd_d2_q <= stage1_data;
                end
            end
        end

        assign rd_valid_o = rd_v2_q;
        assign pipe_data  = rd_d2_q;
    end

    assign rd_data_o = rd_valid_o ? pipe_data : '0;

endmodule

// File: doc/garuda_pingpong_buffer.md
Name: garuda_pingpong_buffer

Overview:
- Generalised N-bank on-chip activation/weight buffer for the Garuda multi-lane datapath.
- Adds per-bank ownership tracking (producer fills, commits; consumer reads, releases), byte-enable writes and a registered, pipelined read with a valid strobe.
- Sits between the DMA/load unit (producer) and the lane array (consumer).
- Replaces the externally driven bank select with internal round-robin bank pointers.

Parameters:
- DEPTH, 4096, words per bank (power of two, >=2)
- DATA_WIDTH, 32, bits per word (multiple of 8)
- NUM_BANKS, 2, number of banks (power of two, >=2)
- RD_LATENCY, 1, cycles from rd_en_i to rd_valid_o (1 or 2)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- wr_en_i  in  1  write strobe into the current producer bank
- wr_addr_i  in  $clog2(DEPTH)  write word address
- wr_data_i  in  DATA_WIDTH  write data
- wr_be_i  in  DATA_WIDTH/8  byte enables
- wr_commit_i  in  1  producer bank complete; hand it to the consumer
- wr_bank_ready_o  out  1  producer bank is EMPTY; writes and commit are accepted
- wr_bank_o  out  $clog2(NUM_BANKS)  producer bank index
- rd_en_i  in  1  read strobe from the current consumer bank
- rd_addr_i  in  $clog2(DEPTH)  read word address
- rd_release_i  in  1  consumer done; return the bank to EMPTY
- rd_bank_valid_o  out  1  consumer bank is FULL; reads and release are accepted
- rd_bank_o  out  $clog2(NUM_BANKS)  consumer bank index
- rd_valid_o  out  1  rd_data_o valid this cycle
- rd_data_o  out  DATA_WIDTH  read data; '0 when rd_valid_o=0
- full_count_o  out  $clog2(NUM_BANKS)+1  number of FULL banks
- err_o  out  1  one-cycle pulse on any illegal request

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All bank states EMPTY; wr/rd bank pointers 0; full_count_o=0.
  - rd_valid_o=0, rd_data_o='0, err_o=0, read pipeline flushed.
  - Array contents are NOT reset and are undefined after power-up.
- Bank states: EMPTY -> FULL on an accepted wr_commit_i. FULL -> EMPTY on an accepted rd_release_i. No other transitions.
- Write:
  - Accepted when wr_en_i && wr_bank_ready_o.
  - Byte i of word wr_addr_i in bank wr_bank_o is updated iff wr_be_i[i]=1. Write completes at the clock edge.
  - wr_en_i with wr_bank_ready_o=0: dropped, err_o pulses.
- Commit:
  - Accepted when wr_commit_i && wr_bank_ready_o.
  - Bank goes FULL and wr_bank_o increments mod NUM_BANKS.
  - A write in the same cycle is applied to the committing bank.
  - Commit while not ready: ignored, err_o pulses.
- Read:
  - Accepted when rd_en_i && rd_bank_valid_o.
  - The array is sampled at the edge; data appears RD_LATENCY cycles later with rd_valid_o=1.
  - Fully pipelined: one accepted read per cycle, returned in order.
  - rd_en_i while rd_bank_valid_o=0: no read issued, err_o pulses.
- Release:
  - Accepted when rd_release_i && rd_bank_valid_o.
  - Bank goes EMPTY and rd_bank_o increments mod NUM_BANKS.
  - A read in the same cycle is accepted and returns pre-release data.
  - Reads already in flight complete normally.
  - Release while not valid: ignored, err_o pulses.
- Commit and release in the same cycle always target different banks. Both take effect; full_count_o is unchanged.
- Read-during-write cannot occur on the same bank, because producer and consumer banks differ whenever both ports are legal.
- full_count_o == NUM_BANKS implies wr_bank_ready_o=0. full_count_o == 0 implies rd_bank_valid_o=0.
- err_o is the OR of all illegal conditions in a cycle and is registered, so it appears one cycle after the offending request.
- Reset mid-operation discards in-flight reads: rd_valid_o drops immediately and all banks become EMPTY.

Decomposition:
- Package garuda_buf_pkg:
  - bank_state_e {BANK_EMPTY, BANK_FULL}
  - Helper localparams for address, bank-index and byte-enable widths.
- One sub-module, garuda_sram_bank: single bank, one byte-enable write port, one registered read port, with no reset on the array.
  - Instantiated NUM_BANKS times; the top module muxes bank read data through the latency pipeline.
- The control FSM, pointers and counters stay in the top module.

Test Plan:
- Reset then idle -> wr_bank_ready_o=1, rd_bank_valid_o=0, full_count_o=0, wr_bank_o=0, rd_valid_o=0.
- Write 0xDEADBEEF to addr 5 with be=4'hF, commit, then read addr 5 -> rd_bank_o=0, rd_valid_o=1 exactly RD_LATENCY cycles after rd_en_i, data 0xDEADBEEF.
- Byte enables: write 0x11223344 with be=4'hF, then 0xAABBCCDD with be=4'b0101 to the same address, commit, read -> 0x11BB33DD.
- Ping-pong, NUM_BANKS=2:
  - Fill and commit bank0, fill and commit bank1 -> full_count_o=2, wr_bank_ready_o=0.
  - A further wr_en_i -> err_o pulse and no array change.
  - Release -> rd_bank_o=1, wr_bank_o=0, wr_bank_ready_o=1.
- Same-cycle commit+release with full_count_o=1 -> full_count_o stays 1, both pointers advance. A read in the release cycle returns the old bank's data.
- Async reset asserted with 2 reads in flight -> rd_valid_o=0 immediately, all banks EMPTY, no stale rd_valid_o after deassert.
